// File: rtl/xor_stream_decryptor.sv
// Stream decryptor for length-prefixed frames. Each ciphertext byte is XORed with
// a Galois LFSR keystream that is reseeded from the stored key at every frame header.
module xor_stream_decryptor #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] key_in,
  input  logic              key_load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done,
  output logic              err
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(8'hB8);
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic              accept;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
    return {1'b0, s[DATA_W-1:1]} ^ (s[0] ? TAPS : '0);
  endfunction

  // An all-zero state would lock the LFSR, so a zero key seeds with 1.
  function automatic logic [DATA_W-1:0] seed_of(input logic [DATA_W-1:0] k);
    return (k == '0) ? ONE : k;
  endfunction

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (key_load) begin
      state_d = S_HDR;
    end else begin
      case (state_q)
        S_HDR:   if (accept && in_data != '0) state_d = S_DATA;
        S_DATA:  if (accept && cnt_q == ONE) state_d = S_HDR;
        default: state_d = state_q;
      endcase
    end
  end

  // key_load wins over any input transfer in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR:   in_ready = !key_load;
      S_DATA:  in_ready = !key_load && (!out_valid_q || out_ready);
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    key_d        = key_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    if (key_load) begin
      key_d       = key_in;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
      if (accept) begin
        case (state_q)
          S_HDR: begin
            if (in_data == '0) begin
              err_d = 1'b1;
            end else begin
              cnt_d  = in_data;
              lfsr_d = seed_of(key_q);
            end
          end
          S_DATA: begin
            out_data_d   = in_data ^ lfsr_q;
            out_valid_d  = 1'b1;
            out_last_d   = (cnt_q == ONE);
            frame_done_d = (cnt_q == ONE);
            cnt_d        = cnt_q - ONE;
            lfsr_d       = lfsr_step(lfsr_q);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q        <= '0;
      lfsr_q       <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      key_q        <= key_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: doc/xor_stream_decryptor.md
XOR_STREAM_DECRYPTOR -- requirements
Module: xor_stream_decryptor

Interface
REQ-001: Parameter DATA_W, default 8, byte width of all data and key paths; only 8 is required to be supported.
REQ-002: clk  input  1  single clock, all state updates on rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: key_in  input  8  cipher key, sampled only when key_load=1.
REQ-005: key_load  input  1  one-cycle strobe: latch key_in, (re)arm the block.
REQ-006: in_data  input  8  stream byte (length header or ciphertext).
REQ-007: in_valid  input  1  in_data valid.
REQ-008: in_ready  output  1  block accepts in_data this cycle; transfer = in_valid & in_ready.
REQ-009: out_data  output  8  decrypted plaintext byte (registered).
REQ-010: out_valid  output  1  out_data valid.
REQ-011: out_ready  input  1  downstream accepts out_data; transfer = out_valid & out_ready.
REQ-012: out_last  output  1  qualifies out_data as final byte of frame.
REQ-013: frame_done  output  1  one-cycle pulse when last ciphertext byte of a frame is accepted.
REQ-014: err  output  1  one-cycle pulse on zero-length header.

Function
REQ-015: Stream format: frame = 1 plaintext length byte L (1..255), then L ciphertext bytes; frames back-to-back.
REQ-016: States: IDLE (no key), HDR (await length byte), DATA (decrypt); FSM state encoding is free.
REQ-017: IDLE: in_ready=0; leave only via key_load -> HDR.
REQ-018: HDR: in_ready=1 regardless of output state; header byte produces no output.
REQ-019: HDR accept, L!=0: cnt<=L, lfsr<=seed, -> DATA; L==0: err=1 next cycle, remain HDR.
REQ-020: Seed = stored key, or 8'h01 if stored key==0 (LFSR lock-up avoidance).
REQ-021: DATA: in_ready = !out_valid | out_ready (single output register, full-throughput when downstream ready).
REQ-022: DATA accept: out_data<=in_data^lfsr, out_valid<=1, out_last<=(cnt==1), cnt<=cnt-1, lfsr advances one step.
REQ-023: LFSR step: next = {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00); first ciphertext byte uses the seed itself.
REQ-024: DATA accept with cnt==1: frame_done=1 next cycle, -> HDR.
REQ-025: Latency: input accept to out_valid = 1 cycle.
REQ-026: out_valid & !out_ready: out_data, out_last held stable; no input accepted in DATA.
REQ-027: Output transfer with no new accept: out_valid<=0 next cycle; simultaneous transfer and accept: register reloads, out_valid stays 1.
REQ-028: key_load has priority over any input transfer in same cycle: input not accepted (in_ready=0 that cycle), key stored, -> HDR, current frame aborted, out_valid<=0, out_last<=0.
REQ-029: Pending output in HDR is still drained normally via out_ready.

Reset
REQ-030: On rst: state=IDLE, key=0, lfsr=0, cnt=0, out_data=0, out_valid=0, out_last=0, frame_done=0, err=0, in_ready=0.
REQ-031: rst mid-frame discards frame and output; block requires new key_load afterwards.

Verification
REQ-032: Before key_load, in_valid=1 -> in_ready=0, out_valid stays 0.
REQ-033: key 0x5A; bytes 0x03,0x12,0x2D,0xAE, out_ready=1 -> out_data 0x48,0x00,0x00; out_last on third; frame_done one pulse.
REQ-034: key 0x00; bytes 0x02,0x01,0xB8 -> out_data 0x00,0x00 (keystream 0x01,0xB8).
REQ-035: Header 0x00 -> err pulse, no output; following header 0x01 + 0x5B with key 0x5A -> out_data 0x01, out_last=1.
REQ-036: out_ready=0 for 5 cycles mid-frame -> out_data stable, in_ready=0, no byte loss or duplication after release.
REQ-037: key_load asserted with in_valid mid-frame -> frame aborted, out_valid=0, next byte treated as header with new key seed.
